elev_call_scheduler: RTL and testbench

- Front-end controller for the 4-floor elevator car datapath.
- Latches floor call requests into a pending set and picks the next target floor with a SCAN (keep-direction) policy.
- Drives the car's one-hot floor request and waits until the car's reported floor matches the target.
- Runs a door dwell timer at each stop, then clears the serviced call.

---
 rtl/elev_pkg.sv | 14 +
 rtl/elev_scan_select.sv | 67 ++++++
 rtl/elev_call_scheduler.sv | 145 ++++++++++++++
 tb/tb_elev_call_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator call scheduler.
package elev_pkg;

  localparam int N_FLOORS_DEF = 4;
  localparam logic [N_FLOORS_DEF-1:0] RESET_FLOOR = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    MOVE,
    DOOR
  } state_e;

endpackage

// File: rtl/elev_scan_select.sv
// SCAN next-target picker: combinational target floor and sweep direction
// from the pending set, the car's one-hot floor and the current direction.
module elev_scan_select
  import elev_pkg::*;
#(
  parameter int N_FLOORS = N_FLOORS_DEF
) (
  input  logic [N_FLOORS-1:0] pending_i,
  input  logic [N_FLOORS-1:0] cur_floor_i,
  input  logic                dir_up_i,
  output logic [N_FLOORS-1:0] target_o,
  output logic                dir_up_o,
  output logic                found_o
);

  logic [N_FLOORS-1:0] above;
  logic [N_FLOORS-1:0] below;
  logic [N_FLOORS-1:0] lo_above;
  logic [N_FLOORS-1:0] hi_below;
  logic                seen;

  always_comb begin
    above    = '0;
    below    = '0;
    hi_below = '0;
    seen     = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (seen) above[i] = pending_i[i];
      if (cur_floor_i[i]) seen = 1'b1;
    end
    seen = 1'b0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (seen) below[i] = pending_i[i];
      if (cur_floor_i[i]) seen = 1'b1;
    end
    // Isolate the lowest set bit of the floors above the car.
    lo_above = above & (~above + N_FLOORS'(1));
    for (int i = 0; i < N_FLOORS; i++) begin
      if (below[i]) begin
        hi_below    = '0;
        hi_below[i] = 1'b1;
      end
    end

    found_o  = |pending_i;
    dir_up_o = dir_up_i;
    target_o = '0;
    if (|(pending_i & cur_floor_i)) begin
      target_o = cur_floor_i;
    end else if (dir_up_i) begin
      if (|above) begin
        target_o = lo_above;
      end else begin
        dir_up_o = 1'b0;
        target_o = hi_below;
      end
    end else begin
      if (|below) begin
        target_o = hi_below;
      end else begin
        dir_up_o = 1'b1;
        target_o = lo_above;
      end
    end
  end

endmodule

// File: rtl/elev_call_scheduler.sv
// Elevator call scheduler: latches calls, picks targets by SCAN, drives the car
// and runs the door dwell. Optional MOVE timeout via `define ELEV_SCHED_TIMEOUT_EN.
module elev_call_scheduler
  import elev_pkg::*;
#(
  parameter int N_FLOORS     = N_FLOORS_DEF,
  parameter int DOOR_CYCLES  = 8,
  parameter int MOVE_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [N_FLOORS-1:0] cur_floor,
  output logic [N_FLOORS-1:0] req_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                dir_up,
  output logic                door_open,
  output logic                busy,
  output logic                fault
);

  // One counter serves the door dwell and the move timeout; they never overlap.
  localparam int CNT_MAX = (DOOR_CYCLES > MOVE_TIMEOUT) ? DOOR_CYCLES : MOVE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  function automatic logic is_onehot(input logic [N_FLOORS-1:0] v);
    return (v != '0) && ((v & (v - N_FLOORS'(1))) == '0);
  endfunction

  state_e              state_q, state_d;
  logic [N_FLOORS-1:0] req_floor_q, req_floor_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic                dir_up_q, dir_up_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_FLOORS-1:0] clr_mask;
  logic [N_FLOORS-1:0] pend_in;
  logic                cur_valid;
  logic [N_FLOORS-1:0] sel_target;
  logic                sel_dir_up;
  logic                sel_found;

  elev_scan_select #(.N_FLOORS(N_FLOORS)) u_scan (
    .pending_i   (pending_q),
    .cur_floor_i (cur_floor),
    .dir_up_i    (dir_up_q),
    .target_o    (sel_target),
    .dir_up_o    (sel_dir_up),
    .found_o     (sel_found)
  );

`ifdef ELEV_SCHED_TIMEOUT_EN
  logic fault_q, fault_d;
`endif

  assign cur_valid = is_onehot(cur_floor);
  assign pend_in   = pending_q | call_req;

  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    dir_up_d    = dir_up_q;
    cnt_d       = '0;
    clr_mask    = '0;
`ifdef ELEV_SCHED_TIMEOUT_EN
    fault_d     = fault_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pending_q != '0 && cur_valid) state_d = SELECT;
      end
      SELECT: begin
        if (!cur_valid || !sel_found) begin
          state_d = IDLE;
        end else begin
          req_floor_d = sel_target;
          dir_up_d    = sel_dir_up;
          if (sel_target == cur_floor) begin
            state_d  = DOOR;
            clr_mask = sel_target;
          end else begin
            state_d = MOVE;
          end
        end
      end
      MOVE: begin
        if (cur_floor == req_floor_q) begin
          state_d  = DOOR;
          clr_mask = req_floor_q;
        end
`ifdef ELEV_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MOVE_TIMEOUT - 1)) begin
          clr_mask = req_floor_q;
          fault_d  = 1'b1;
          state_d  = ((pend_in & ~req_floor_q) != '0) ? SELECT : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DOOR: begin
        clr_mask = req_floor_q;
        if (cnt_q == CNT_W'(DOOR_CYCLES - 1)) begin
          state_d = ((pend_in & ~req_floor_q) != '0) ? SELECT : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = pend_in & ~clr_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_floor_q <= N_FLOORS'(RESET_FLOOR);
      pending_q   <= '0;
      dir_up_q    <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_floor_q <= req_floor_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ELEV_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign req_floor = req_floor_q;
  assign pending   = pending_q;
  assign dir_up    = dir_up_q;
  assign door_open = (state_q == DOOR);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_elev_call_scheduler.sv
// Scoreboard bench for elev_call_scheduler: expected service floors are queued
// as calls are driven and checked when the door opens.
module tb_elev_call_scheduler;

  localparam int NF = 4;
  localparam int DC = 8;
  localparam int MT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NF-1:0] call_req = '0;
  logic [NF-1:0] cur_floor = 4'b0001;
  logic [NF-1:0] req_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          door_open;
  logic          busy;
  logic          fault;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [NF-1:0] sb_q[$];
  logic [NF-1:0] sb_exp;
  logic          door_q = 1'b0;

  elev_call_scheduler #(
    .N_FLOORS    (NF),
    .DOOR_CYCLES (DC),
    .MOVE_TIMEOUT(MT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .call_req  (call_req),
    .cur_floor (cur_floor),
    .req_floor (req_floor),
    .pending   (pending),
    .dir_up    (dir_up),
    .door_open (door_open),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  // Every door opening must match the next floor the bench expects to be served.
  always @(negedge clk) begin
    if (door_open && !door_q) begin
      if (sb_q.size() == 0) begin
        check("svc_unexpected", 32'(req_floor), 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("svc_floor", 32'(req_floor), 32'(sb_exp));
      end
    end
    door_q = door_open;
  end

  task automatic run_door(input int already);
    int n;
    int g;
    n = already;
    g = 0;
    while (!door_open && g < 100) begin
      tick();
      g++;
    end
    check("door_seen", 32'(door_open), 32'd1);
    while (door_open && g < 200) begin
      n++;
      tick();
      g++;
    end
    check("door_len", 32'(n), 32'(DC));
  endtask

  task check_reset_vals(input string tag);
    check({tag, "_req"},  32'(req_floor), 32'h1);
    check({tag, "_pend"}, 32'(pending),   32'h0);
    check({tag, "_dir"},  32'(dir_up),    32'h1);
    check({tag, "_door"}, 32'(door_open), 32'h0);
    check({tag, "_busy"}, 32'(busy),      32'h0);
    check({tag, "_fault"}, 32'(fault),    32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check_reset_vals("rst");
    #1 rst = 1'b0;
    tick();

    // Single call to floor 2 from floor 0
    call_req = 4'b0100;
    sb_q.push_back(4'b0100);
    tick();
    call_req = '0;
    check("t1_pend", 32'(pending), 32'h4);
    check("t1_busy_idle", 32'(busy), 32'h0);
    tick();
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_req_hold", 32'(req_floor), 32'h1);
    tick();
    check("t1_req", 32'(req_floor), 32'h4);
    tick();
    check("t1_move_hold", 32'(req_floor), 32'h4);
    cur_floor = 4'b0100;
    run_door(0);
    check("t1_pend_clr", 32'(pending), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);

    // Calls above and below while sweeping up: up first, then reverse
    call_req = 4'b1001;
    sb_q.push_back(4'b1000);
    sb_q.push_back(4'b0001);
    tick();
    call_req = '0;
    check("t2_pend", 32'(pending), 32'h9);
    tick();
    tick();
    check("t2_req_up", 32'(req_floor), 32'h8);
    check("t2_dir_up", 32'(dir_up), 32'h1);
    cur_floor = 4'b1000;
    run_door(0);
    check("t2_pend_mid", 32'(pending), 32'h1);
    tick();
    check("t2_req_dn", 32'(req_floor), 32'h1);
    check("t2_dir_dn", 32'(dir_up), 32'h0);
    cur_floor = 4'b0001;
    run_door(0);
    check("t2_pend_end", 32'(pending), 32'h0);

    // Call at the current floor: straight from SELECT into DOOR
    cur_floor = 4'b0010;
    call_req  = 4'b0010;
    sb_q.push_back(4'b0010);
    tick();
    call_req = '0;
    tick();
    tick();
    check("t3_req", 32'(req_floor), 32'h2);
    check("t3_door_now", 32'(door_open), 32'h1);
    check("t3_pend", 32'(pending), 32'h0);
    // A call to the open-door floor is absorbed
    call_req = 4'b0010;
    tick();
    call_req = '0;
    check("t4_absorb", 32'(pending), 32'h0);
    run_door(1);
    check("t4_pend_end", 32'(pending), 32'h0);
    check("t4_idle", 32'(busy), 32'h0);

    // Reset in the middle of a move discards everything
    cur_floor = 4'b0001;
    call_req  = 4'b1010;
    tick();
    call_req = '0;
    tick();
    tick();
    check("t5_req", 32'(req_floor), 32'h2);
    check("t5_dir", 32'(dir_up), 32'h1);
    check("t5_pend", 32'(pending), 32'ha);
    tick();
    #2 rst = 1'b1;
    #1;
    check_reset_vals("t5_async");
    tick();
    cur_floor = 4'b0010;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t5_no_door", 32'(door_open), 32'h0);
    check("t5_idle", 32'(busy), 32'h0);
    check("t5_pend_after", 32'(pending), 32'h0);

    // New call mid-move accumulates without re-targeting
    cur_floor = 4'b0001;
    call_req  = 4'b0100;
    sb_q.push_back(4'b0100);
    sb_q.push_back(4'b0010);
    tick();
    call_req = '0;
    tick();
    tick();
    check("t6_req", 32'(req_floor), 32'h4);
    call_req = 4'b0010;
    tick();
    call_req = '0;
    check("t6_pend", 32'(pending), 32'h6);
    tick();
    tick();
    check("t6_no_retarget", 32'(req_floor), 32'h4);
    cur_floor = 4'b0100;
    run_door(0);
    tick();
    check("t6_req2", 32'(req_floor), 32'h2);
    check("t6_dir2", 32'(dir_up), 32'h0);
    cur_floor = 4'b0010;
    run_door(0);
    check("t6_pend_end", 32'(pending), 32'h0);

`ifdef ELEV_SCHED_TIMEOUT_EN
    // Move timeout drops the call, sets fault and moves on
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur_floor = 4'b0001;
    call_req  = 4'b1100;
    tick();
    call_req = '0;
    tick();
    tick();
    check("t7_req", 32'(req_floor), 32'h4);
    cur_floor = 4'b0000;
    repeat (MT - 1) tick();
    check("t7_fault_pre", 32'(fault), 32'h0);
    tick();
    check("t7_fault", 32'(fault), 32'h1);
    check("t7_pend", 32'(pending), 32'h8);
    cur_floor = 4'b0001;
    tick();
    check("t7_req_next", 32'(req_floor), 32'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    repeat (3) tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
